// File: rtl/conv2_pkg.sv
// Shared constants and grant encoding for the conv2 line SRAM controller.
package conv2_pkg;

  localparam int CONV2_DP = 16;
  localparam int CONV2_DW = 96;
  localparam int CONV2_AW = 10;
  localparam int CONV2_MW = 1;

  // Which requester owns the SRAM port (or owned it last).
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/conv2_sram_arb_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the writer, bit 1 the reader.
// last_grant is the arbiter's only state and is exported for observation.
module rr_arb2
  import conv2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output gnt_e       last_grant
);

  // Single winner; on a tie the side that did not win last time goes.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == GNT_WR) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the last winner; starts as READ so the writer wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_RD;
    end else if (gnt[0]) begin
      last_grant <= GNT_WR;
    end else if (gnt[1]) begin
      last_grant <= GNT_RD;
    end
  end

endmodule

// File: rtl/conv2_sram_arb.sv
// Sharing controller for the single-port conv2 line SRAM.
// Handshake: a transfer happens in a cycle where valid=1 and ready=1; ready
// is combinational from valid, address and the registered line bitmap, and
// the requester holds address/data stable while valid=1 and ready=0.
module conv2_sram_arb
  import conv2_pkg::*;
#(
  parameter int DP = CONV2_DP,
  parameter int DW = CONV2_DW,
  parameter int AW = CONV2_AW,
  parameter int MW = CONV2_MW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_release,
  output logic          rd_rvalid,
  output logic [DW-1:0] rd_rdata,
  input  logic          frame_clr,
  output logic [DP-1:0] line_valid,
  output logic          addr_err,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [MW-1:0] sram_wem,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  localparam int            LW   = $clog2(DP);
  localparam logic [AW-1:0] DP_A = AW'(DP);

  logic          w_in;
  logic          r_in;
  logic          w_elig;
  logic          r_elig;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          gnt_wr;
  logic          gnt_rd;
  gnt_e          arb_last_grant;
  logic          rvalid_q;
  logic          addr_err_q;
  logic [DP-1:0] line_valid_q;

  // Out-of-range requests bypass the bitmap so they always complete.
  assign w_in   = (wr_addr < DP_A);
  assign r_in   = (rd_addr < DP_A);
  assign w_elig = wr_valid & (~w_in | ~line_valid_q[wr_addr[LW-1:0]]);
  assign r_elig = rd_valid & (~r_in | line_valid_q[rd_addr[LW-1:0]]);

  // No grants while the bitmap is being cleared or the block is in reset.
  assign req    = (rst | frame_clr) ? 2'b00 : {r_elig, w_elig};

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .last_grant (arb_last_grant)
  );

  assign gnt_wr   = gnt[0];
  assign gnt_rd   = gnt[1];
  assign wr_ready = gnt_wr;
  assign rd_ready = gnt_rd;

  // SRAM port mux; idle address/data are driven to zero to stay X-free.
  always_comb begin
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    sram_wem  = '0;
    sram_addr = '0;
    sram_din  = '0;
    if (gnt_wr) begin
      sram_cs   = w_in;
      sram_we   = w_in;
      sram_wem  = {MW{w_in}};
      sram_addr = wr_addr;
      sram_din  = wr_data;
    end else if (gnt_rd) begin
      sram_cs   = r_in;
      sram_addr = rd_addr;
    end
  end

  // Read response and address-error pulses, one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rvalid_q   <= gnt_rd;
      addr_err_q <= (gnt_wr & ~w_in) | (gnt_rd & ~r_in);
    end
  end

  // Line bitmap: set on in-range write, cleared on releasing read or new frame.
  always_ff @(posedge clk) begin
    if (rst || frame_clr) begin
      line_valid_q <= '0;
    end else if (gnt_wr && w_in) begin
      line_valid_q[wr_addr[LW-1:0]] <= 1'b1;
    end else if (gnt_rd && r_in && rd_release) begin
      line_valid_q[rd_addr[LW-1:0]] <= 1'b0;
    end
  end

  assign rd_rvalid  = rvalid_q;
  assign rd_rdata   = sram_dout;
  assign addr_err   = addr_err_q;
  assign line_valid = line_valid_q;

endmodule
